// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared types and sizing helpers for the perf counter bank
package perf_pkg;

    typedef enum logic {
        RD_LIVE     = 1'b0,
        RD_SNAPSHOT = 1'b1
    } rd_src_e;

    function automatic longint unsigned counter_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// rtl/perf_counter_cell.sv - one live counter with its snapshot register and sticky overflow
module perf_counter_cell
    import perf_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    input  logic             snapshot,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] snap,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(counter_max(WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            snap     <= '0;
            overflow <= 1'b0;
        end else begin
            // Snapshot takes the pre-edge count, so snapshot+clear is an atomic read-and-reset.
            if (snapshot) begin
                snap <= count;
            end
            if (clear) begin
                count    <= '0;
                overflow <= 1'b0;
            end else if (inc) begin
                if (count == MAX) begin
                    overflow <= 1'b1;
                    if (SATURATE == 0) begin
                        count <= '0;
                    end
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of event counters with snapshot and a registered read port
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_COUNTERS  = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int SATURATE      = 0,
    localparam int IDX_W        = idx_width(NUM_COUNTERS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_COUNTERS-1:0]  events,
    input  logic                     clear,
    input  logic                     snapshot,
    input  logic                     rd_en,
    input  logic [IDX_W-1:0]         rd_idx,
    input  logic                     rd_src,
    output logic                     rd_valid,
    output logic [COUNTER_WIDTH-1:0] rd_data,
    output logic [NUM_COUNTERS-1:0]  overflow
);

    localparam logic [IDX_W:0] NUM_L = (IDX_W + 1)'(NUM_COUNTERS);

    logic [COUNTER_WIDTH-1:0] live_cnt [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] snap_cnt [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] rd_next;

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : gen_cell
        perf_counter_cell #(
            .WIDTH    (COUNTER_WIDTH),
            .SATURATE (SATURATE)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc      (enable & events[i]),
            .clear    (clear),
            .snapshot (snapshot),
            .count    (live_cnt[i]),
            .snap     (snap_cnt[i]),
            .overflow (overflow[i])
        );
    end

    // Out-of-range indices read as zero rather than aliasing onto a real channel.
    always_comb begin
        rd_next = '0;
        if ({1'b0, rd_idx} < NUM_L) begin
            if (rd_src_e'(rd_src) == RD_SNAPSHOT) begin
                rd_next = snap_cnt[rd_idx];
            end else begin
                rd_next = live_cnt[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - scoreboard bench for perf_counter_bank in wrap and saturate builds
module tb_perf_counter_bank;

    localparam int N   = 5;
    localparam int W   = 4;
    localparam int MAXV = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [N-1:0] events;
    logic         clear;
    logic         snapshot;
    logic         rd_en;
    logic [2:0]   rd_idx;
    logic         rd_src;

    logic         rd_valid_w, rd_valid_s;
    logic [W-1:0] rd_data_w, rd_data_s;
    logic [N-1:0] overflow_w, overflow_s;

    int tests = 0;
    int fails = 0;

    int live_m [2][N];
    int snap_m [2][N];
    bit ovf_m  [2][N];
    int q_w[$];
    int q_s[$];

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_COUNTERS(N), .COUNTER_WIDTH(W), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .enable(enable), .events(events), .clear(clear),
        .snapshot(snapshot), .rd_en(rd_en), .rd_idx(rd_idx), .rd_src(rd_src),
        .rd_valid(rd_valid_w), .rd_data(rd_data_w), .overflow(overflow_w)
    );

    perf_counter_bank #(.NUM_COUNTERS(N), .COUNTER_WIDTH(W), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .events(events), .clear(clear),
        .snapshot(snapshot), .rd_en(rd_en), .rd_idx(rd_idx), .rd_src(rd_src),
        .rd_valid(rd_valid_s), .rd_data(rd_data_s), .overflow(overflow_s)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ovf_vec(input int d);
        int v = 0;
        for (int i = 0; i < N; i++) if (ovf_m[d][i]) v |= (1 << i);
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++) begin
                live_m[d][i] = 0;
                snap_m[d][i] = 0;
                ovf_m[d][i]  = 1'b0;
            end
    endtask

    // Drive one cycle of inputs and advance the reference model by that cycle.
    task automatic apply(input logic [N-1:0] ev, input bit en, input bit clr, input bit snp,
                         input bit ren, input int idx, input bit src);
        enable   = en;
        events   = ev;
        clear    = clr;
        snapshot = snp;
        rd_en    = ren;
        rd_idx   = 3'(idx);
        rd_src   = src;
        for (int d = 0; d < 2; d++) begin
            if (ren) begin
                int v = 0;
                if (idx < N) v = src ? snap_m[d][idx] : live_m[d][idx];
                if (d == 0) q_w.push_back(v); else q_s.push_back(v);
            end
            for (int i = 0; i < N; i++) begin
                if (snp) snap_m[d][i] = live_m[d][i];
                if (clr) begin
                    live_m[d][i] = 0;
                    ovf_m[d][i]  = 1'b0;
                end else if (en && ev[i]) begin
                    if (live_m[d][i] == MAXV) begin
                        ovf_m[d][i]  = 1'b1;
                        live_m[d][i] = (d == 1) ? MAXV : 0;
                    end else begin
                        live_m[d][i] = live_m[d][i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] ev, input bit en, input bit clr, input bit snp,
                         input bit ren, input int idx, input bit src);
        apply(ev, en, clr, snp, ren, idx, src);
        @(posedge clk);
        @(negedge clk);
        chk("overflow_wrap", int'(overflow_w), ovf_vec(0));
        chk("overflow_sat", int'(overflow_s), ovf_vec(1));
    endtask

    task automatic rd(input int idx, input bit src);
        cycle('0, 1'b1, 1'b0, 1'b0, 1'b1, idx, src);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle('0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Monitor: every rd_valid must match the oldest outstanding expected read.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (rd_valid_w) begin
                if (q_w.size() == 0) chk("rd_valid_wrap_unexpected", 1, 0);
                else chk("rd_data_wrap", int'(rd_data_w), q_w.pop_front());
            end else if (q_w.size() != 0) begin
                chk("rd_valid_wrap_missing", 0, 1);
                void'(q_w.pop_front());
            end
            if (rd_valid_s) begin
                if (q_s.size() == 0) chk("rd_valid_sat_unexpected", 1, 0);
                else chk("rd_data_sat", int'(rd_data_s), q_s.pop_front());
            end else if (q_s.size() != 0) begin
                chk("rd_valid_sat_missing", 0, 1);
                void'(q_s.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b0; events = '0; clear = 1'b0; snapshot = 1'b0;
        rd_en = 1'b0; rd_idx = '0; rd_src = 1'b0;
        model_reset();
        #1;
        chk("reset_rd_valid", int'(rd_valid_w) + int'(rd_valid_s), 0);
        chk("reset_rd_data", int'(rd_data_w) + int'(rd_data_s), 0);
        chk("reset_overflow", int'(overflow_w) + int'(overflow_s), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic count on channels 0 and 2
        for (int k = 0; k < 10; k++) cycle(5'b00101, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) rd(i, 1'b0);

        // Wrap / saturate on channel 1
        cycle('0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 17; k++) cycle(5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rd(1, 1'b0);
        cycle('0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        rd(1, 1'b0);

        // Channel 2: exactly max events, then past max
        for (int k = 0; k < 15; k++) cycle(5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rd(2, 1'b0);
        for (int k = 0; k < 5; k++) cycle(5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rd(2, 1'b0);

        // Atomic snapshot+clear with a same-cycle event
        cycle('0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        for (int k = 0; k < 7; k++) cycle(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        cycle(5'b00001, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        rd(0, 1'b1);
        rd(0, 1'b0);
        cycle(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rd(0, 1'b0);

        // Back-to-back reads of an incrementing channel, then out-of-range indices
        for (int k = 0; k < 20; k++) cycle(5'b01000, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        rd(5, 1'b0);
        rd(7, 1'b1);

        // Enable low gates events but not reads
        for (int k = 0; k < 5; k++) cycle(5'b11111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < N; i++) rd(i, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 400; k++)
            cycle(5'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7), 1'($urandom_range(0, 1)));

        // Reset asserted after an accepted read: outputs clear asynchronously
        apply(5'b11111, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_rd_valid", int'(rd_valid_w) + int'(rd_valid_s), 0);
        chk("async_reset_rd_data", int'(rd_data_w) + int'(rd_data_s), 0);
        chk("async_reset_overflow", int'(overflow_w) + int'(overflow_s), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd_en = 1'b0;
        events = '0;
        idle(3);
        for (int i = 0; i < N; i++) rd(i, 1'b0);
        for (int i = 0; i < N; i++) rd(i, 1'b1);

        // Reset asserted while a read request is pending: no rd_valid afterwards
        enable = 1'b1; events = 5'b11111; rd_en = 1'b1; rd_idx = 3'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("pending_reset_rd_valid", int'(rd_valid_w) + int'(rd_valid_s), 0);
        @(negedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        events = '0;
        rst_n = 1'b1;
        idle(3);
        rd(3, 1'b0);
        idle(2);

        chk("queue_drained", q_w.size() + q_s.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
